// File: rtl/csr_regs.sv
// ---------------------------------------------------------------------------
// csr_regs -- machine-mode CSR file for a single-hart RV64 core.
//
// Holds mstatus, mie, mtvec, mscratch, mepc, mcause and the free-running
// mcycle counter. There are two independent write/read ports:
//   * the execute stage (we_i / waddr_i / wdata_i, raddr_i -> rdata_o)
//   * the CLINT (clint_we_i / clint_waddr_i / clint_data_i,
//     clint_raddr_i -> clint_data_o)
// When both ports write the same CSR in one cycle, the execute-stage write
// wins. Writes to different CSRs both land in the same cycle.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous, active-low reset (clears every CSR)
//   we_i              execute-stage write enable
//   waddr_i           execute-stage write address (bits [11:0] decoded)
//   wdata_i           execute-stage write data
//   raddr_i           execute-stage read address (bits [11:0] decoded)
//   rdata_o           execute-stage read data (combinational, write-bypassed)
//   clint_we_i        CLINT write enable
//   clint_waddr_i     CLINT write address (bits [11:0] decoded)
//   clint_data_i      CLINT write data
//   clint_raddr_i     CLINT read address (bits [11:0] decoded)
//   clint_data_o      CLINT read data (combinational, write-bypassed)
//   csr_mtvec         registered mtvec
//   csr_mepc          registered mepc
//   csr_mstatus       registered mstatus
//   global_int_en_o   registered mstatus.MIE (bit 3)
// ---------------------------------------------------------------------------
module csr_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [63:0] waddr_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] raddr_i,
    output logic [63:0] rdata_o,
    input  logic        clint_we_i,
    input  logic [63:0] clint_waddr_i,
    input  logic [63:0] clint_data_i,
    input  logic [63:0] clint_raddr_i,
    output logic [63:0] clint_data_o,
    output logic [63:0] csr_mtvec,
    output logic [63:0] csr_mepc,
    output logic [63:0] csr_mstatus,
    output logic        global_int_en_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    logic [63:0] mstatus_q,  mstatus_d;
    logic [63:0] mie_q,      mie_d;
    logic [63:0] mtvec_q,    mtvec_d;
    logic [63:0] mscratch_q, mscratch_d;
    logic [63:0] mepc_q,     mepc_d;
    logic [63:0] mcause_q,   mcause_d;
    logic [63:0] mcycle_q,   mcycle_d;

    // Only the low 12 bits of every address select a CSR.
    logic [11:0] ex_wa;
    logic [11:0] ex_ra;
    logic [11:0] cl_wa;
    logic [11:0] cl_ra;
    logic [63:0] ex_wval;
    logic [63:0] cl_wval;
    logic        unused_addr_bits;

    assign ex_wa = waddr_i[11:0];
    assign ex_ra = raddr_i[11:0];
    assign cl_wa = clint_waddr_i[11:0];
    assign cl_ra = clint_raddr_i[11:0];

    assign unused_addr_bits = ^{waddr_i[63:12], raddr_i[63:12],
                                clint_waddr_i[63:12], clint_raddr_i[63:12]};

    function automatic logic is_impl(input logic [11:0] a);
        case (a)
            ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
            ADDR_MEPC, ADDR_MCAUSE, ADDR_MCYCLE: is_impl = 1'b1;
            default:                             is_impl = 1'b0;
        endcase
    endfunction

    // mepc is always 4-byte aligned; mtvec supports direct mode only, so
    // its MODE field [1:0] is hardwired to zero.
    function automatic logic [63:0] legalize(input logic [11:0] a,
                                             input logic [63:0] d);
        logic [63:0] r;
        r = d;
        if (a == ADDR_MEPC || a == ADDR_MTVEC) begin
            r[1:0] = 2'b00;
        end
        return r;
    endfunction

    function automatic logic [63:0] read_csr(input logic [11:0] a);
        case (a)
            ADDR_MSTATUS:  read_csr = mstatus_q;
            ADDR_MIE:      read_csr = mie_q;
            ADDR_MTVEC:    read_csr = mtvec_q;
            ADDR_MSCRATCH: read_csr = mscratch_q;
            ADDR_MEPC:     read_csr = mepc_q;
            ADDR_MCAUSE:   read_csr = mcause_q;
            ADDR_MCYCLE:   read_csr = mcycle_q;
            default:       read_csr = 64'd0;
        endcase
    endfunction

    assign ex_wval = legalize(ex_wa, wdata_i);
    assign cl_wval = legalize(cl_wa, clint_data_i);

    // Next state: mcycle free-runs, then the CLINT write is applied, then the
    // execute write, so the execute port wins a same-address collision and
    // any write to mcycle replaces that cycle's increment.
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;

        if (clint_we_i) begin
            case (cl_wa)
                ADDR_MSTATUS:  mstatus_d  = cl_wval;
                ADDR_MIE:      mie_d      = cl_wval;
                ADDR_MTVEC:    mtvec_d    = cl_wval;
                ADDR_MSCRATCH: mscratch_d = cl_wval;
                ADDR_MEPC:     mepc_d     = cl_wval;
                ADDR_MCAUSE:   mcause_d   = cl_wval;
                ADDR_MCYCLE:   mcycle_d   = cl_wval;
                default: ;
            endcase
        end

        if (we_i) begin
            case (ex_wa)
                ADDR_MSTATUS:  mstatus_d  = ex_wval;
                ADDR_MIE:      mie_d      = ex_wval;
                ADDR_MTVEC:    mtvec_d    = ex_wval;
                ADDR_MSCRATCH: mscratch_d = ex_wval;
                ADDR_MEPC:     mepc_d     = ex_wval;
                ADDR_MCAUSE:   mcause_d   = ex_wval;
                ADDR_MCYCLE:   mcycle_d   = ex_wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= 64'd0;
            mie_q      <= 64'd0;
            mtvec_q    <= 64'd0;
            mscratch_q <= 64'd0;
            mepc_q     <= 64'd0;
            mcause_q   <= 64'd0;
            mcycle_q   <= 64'd0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end

    // Read ports forward a same-cycle write so a reader never sees stale data.
    // The CLINT port honours the same priority as the register update.
    always_comb begin
        if (we_i && is_impl(ex_wa) && ex_wa == ex_ra) begin
            rdata_o = ex_wval;
        end else begin
            rdata_o = read_csr(ex_ra);
        end
    end

    always_comb begin
        if (we_i && is_impl(ex_wa) && ex_wa == cl_ra) begin
            clint_data_o = ex_wval;
        end else if (clint_we_i && is_impl(cl_wa) && cl_wa == cl_ra) begin
            clint_data_o = cl_wval;
        end else begin
            clint_data_o = read_csr(cl_ra);
        end
    end

    // Direct outputs are deliberately unbypassed: the CLINT does a
    // read-modify-write of mstatus and must see the value before its write.
    assign csr_mtvec       = mtvec_q;
    assign csr_mepc        = mepc_q;
    assign csr_mstatus     = mstatus_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_regs.sv
// Bench for csr_regs. The reference model is a flat 4096-entry CSR address
// space; only implemented addresses are ever written in it, so unimplemented
// reads naturally return 0. Inputs change 1 time unit after a rising edge and
// outputs are sampled 2 units after that, well away from the next edge.
module tb_csr_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [63:0] waddr_i;
    logic [63:0] wdata_i;
    logic [63:0] raddr_i;
    logic [63:0] rdata_o;
    logic        clint_we_i;
    logic [63:0] clint_waddr_i;
    logic [63:0] clint_data_i;
    logic [63:0] clint_raddr_i;
    logic [63:0] clint_data_o;
    logic [63:0] csr_mtvec;
    logic [63:0] csr_mepc;
    logic [63:0] csr_mstatus;
    logic        global_int_en_o;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mdl [4096];

    always #5 clk = ~clk;

    csr_regs dut (
        .clk             (clk),
        .rst             (rst),
        .we_i            (we_i),
        .waddr_i         (waddr_i),
        .wdata_i         (wdata_i),
        .raddr_i         (raddr_i),
        .rdata_o         (rdata_o),
        .clint_we_i      (clint_we_i),
        .clint_waddr_i   (clint_waddr_i),
        .clint_data_i    (clint_data_i),
        .clint_raddr_i   (clint_raddr_i),
        .clint_data_o    (clint_data_o),
        .csr_mtvec       (csr_mtvec),
        .csr_mepc        (csr_mepc),
        .csr_mstatus     (csr_mstatus),
        .global_int_en_o (global_int_en_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit impl(input int a);
        return a == 'h300 || a == 'h304 || a == 'h305 || a == 'h340 ||
               a == 'h341 || a == 'h342 || a == 'hB00;
    endfunction

    function automatic logic [63:0] legal(input int a, input logic [63:0] d);
        logic [63:0] r;
        r = d;
        if (a == 'h341 || a == 'h305) r = d & ~64'd3;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Random address whose low 12 bits come from a small pool (implemented
    // plus a few unimplemented ones) and whose upper bits are garbage.
    function automatic logic [63:0] pick_addr();
        int pool [10] = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'hB00,
                          'h7C0, 'h000, 'hFFF};
        logic [63:0] r;
        r = rnd64();
        r[11:0] = 12'(pool[$urandom_range(0, 9)]);
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4096; i++) mdl[i] = 64'd0;
    endtask

    task automatic idle();
        we_i = 1'b0;
        clint_we_i = 1'b0;
    endtask

    task automatic exw(input logic [63:0] a, input logic [63:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
    endtask

    task automatic clw(input logic [63:0] a, input logic [63:0] d);
        clint_we_i = 1'b1; clint_waddr_i = a; clint_data_i = d;
    endtask

    task automatic check_outputs();
        int ra, ca, wa, cwa;
        logic [63:0] exp_rd, exp_cd;
        ra  = int'(raddr_i[11:0]);
        ca  = int'(clint_raddr_i[11:0]);
        wa  = int'(waddr_i[11:0]);
        cwa = int'(clint_waddr_i[11:0]);
        exp_rd = mdl[ra];
        if (we_i && impl(wa) && wa == ra) exp_rd = legal(wa, wdata_i);
        exp_cd = mdl[ca];
        if (we_i && impl(wa) && wa == ca)            exp_cd = legal(wa, wdata_i);
        else if (clint_we_i && impl(cwa) && cwa == ca) exp_cd = legal(cwa, clint_data_i);
        chk("rdata",   rdata_o,      exp_rd);
        chk("cdata",   clint_data_o, exp_cd);
        chk("mtvec",   csr_mtvec,    mdl['h305]);
        chk("mepc",    csr_mepc,     mdl['h341]);
        chk("mstatus", csr_mstatus,  mdl['h300]);
        chk("gie",     64'(global_int_en_o), 64'(mdl['h300][3]));
    endtask

    // One clock: check combinational view, take the edge, advance the model.
    task automatic cycle();
        int wa, cwa;
        #1;
        check_outputs();
        @(posedge clk);
        if (rst) begin
            wa  = int'(waddr_i[11:0]);
            cwa = int'(clint_waddr_i[11:0]);
            mdl['hB00] = mdl['hB00] + 64'd1;
            if (clint_we_i && impl(cwa)) mdl[cwa] = legal(cwa, clint_data_i);
            if (we_i && impl(wa))        mdl[wa]  = legal(wa, wdata_i);
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        clint_we_i = 1'b0; clint_waddr_i = '0; clint_data_i = '0; clint_raddr_i = '0;
        clear_model();

        // Reset state.
        #12;
        raddr_i = 64'hB00; clint_raddr_i = 64'h300;
        #1;
        chk("rst_mcycle", rdata_o, 64'd0);
        check_outputs();

        // Release between edges; mcycle counts each edge seen after release,
        // so after five edges it reads exactly 5.
        rst = 1'b1;
        repeat (5) cycle();
        #1;
        chk("idle5_mcycle", rdata_o, 64'd5);
        raddr_i = 64'h342; #1;
        chk("idle5_mcause", rdata_o, 64'd0);

        // mstatus.MIE from both ports.
        exw(64'h300, 64'h8);
        cycle(); idle(); #1;
        chk("mie_set_gie", 64'(global_int_en_o), 64'd1);
        chk("mie_set_mstatus", csr_mstatus, 64'h8);
        clw(64'h300, 64'h80);
        cycle(); idle(); #1;
        chk("mie_clr_gie", 64'(global_int_en_o), 64'd0);
        chk("mie_clr_mstatus", csr_mstatus, 64'h80);

        // Same-address collision, then disjoint writes.
        exw(64'h341, 64'h1000); clw(64'h341, 64'h2000); clint_raddr_i = 64'h341;
        cycle(); idle(); #1;
        chk("collide_mepc", csr_mepc, 64'h1000);
        exw(64'h341, 64'h1004); clw(64'h342, 64'd11);
        cycle(); idle(); raddr_i = 64'h342; #1;
        chk("both_mepc", csr_mepc, 64'h1004);
        chk("both_mcause", rdata_o, 64'd11);

        // mtvec masking and same-cycle bypass.
        exw(64'hABC0_0000_0000_0305, 64'h8000_0003); raddr_i = 64'h305; #1;
        chk("mtvec_bypass", rdata_o, 64'h8000_0000);
        cycle(); idle(); #1;
        chk("mtvec_reg", csr_mtvec, 64'h8000_0000);

        // mcycle wrap.
        exw(64'hB00, 64'hFFFF_FFFF_FFFF_FFFE); raddr_i = 64'hB00;
        cycle(); idle(); #1;
        chk("wrap_0", rdata_o, 64'hFFFF_FFFF_FFFF_FFFE);
        cycle(); #1;
        chk("wrap_1", rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(); #1;
        chk("wrap_2", rdata_o, 64'd0);

        // Unimplemented address.
        exw(64'h5555_0000_0000_07C0, 64'h1234); raddr_i = 64'h7C0; clint_raddr_i = 64'h7C0; #1;
        chk("unimpl_bypass", rdata_o, 64'd0);
        cycle(); idle(); #1;
        chk("unimpl_read", rdata_o, 64'd0);
        chk("unimpl_mepc", csr_mepc, 64'h1004);
        chk("unimpl_mtvec", csr_mtvec, 64'h8000_0000);
        chk("unimpl_mstatus", csr_mstatus, 64'h80);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            we_i          = ($urandom_range(0, 2) != 0);
            clint_we_i    = ($urandom_range(0, 2) != 0);
            waddr_i       = pick_addr();
            clint_waddr_i = pick_addr();
            raddr_i       = pick_addr();
            clint_raddr_i = pick_addr();
            wdata_i       = rnd64();
            clint_data_i  = rnd64();
            if ($urandom_range(0, 3) == 0) clint_waddr_i[11:0] = waddr_i[11:0];
            if ($urandom_range(0, 3) == 0) raddr_i[11:0] = waddr_i[11:0];
            if ($urandom_range(0, 3) == 0) clint_raddr_i[11:0] = clint_waddr_i[11:0];
            cycle();
        end

        // Async reset in the middle of a write: outputs clear with no edge,
        // and the pending write is discarded.
        exw(64'h300, 64'h8); raddr_i = 64'hB00; clint_raddr_i = 64'h341;
        #2;
        rst = 1'b0;
        clear_model();
        #1;
        chk("arst_mcycle", rdata_o, 64'd0);
        chk("arst_mstatus", csr_mstatus, 64'd0);
        chk("arst_gie", 64'(global_int_en_o), 64'd0);
        chk("arst_mepc", clint_data_o, 64'd0);
        @(posedge clk); #1;
        chk("arst_hold_mstatus", csr_mstatus, 64'd0);
        idle();
        #2;
        rst = 1'b1;
        repeat (3) cycle();
        #1;
        chk("post_rst_mcycle", rdata_o, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_regs.md
CSR_REGS -- requirements
Module: csr_regs

Interface
REQ-001 The block SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-002 The block SHALL have: rst  input  1  asynchronous, active-low reset; asserted low clears all state immediately.
REQ-003 The block SHALL have: we_i  input  1  ex write enable.
REQ-004 The block SHALL have: waddr_i  input  64  ex write address; only [11:0] decoded.
REQ-005 The block SHALL have: wdata_i  input  64  ex write data.
REQ-006 The block SHALL have: raddr_i  input  64  ex read address; only [11:0] decoded.
REQ-007 The block SHALL have: rdata_o  output  64  ex read data, combinational.
REQ-008 The block SHALL have: clint_we_i  input  1  CLINT write enable.
REQ-009 The block SHALL have: clint_waddr_i  input  64  CLINT write address; only [11:0] decoded.
REQ-010 The block SHALL have: clint_data_i  input  64  CLINT write data.
REQ-011 The block SHALL have: clint_raddr_i  input  64  CLINT read address.
REQ-012 The block SHALL have: clint_data_o  output  64  CLINT read data, combinational.
REQ-013 The block SHALL have: csr_mtvec, csr_mepc, csr_mstatus  output  64 each  direct register values.
REQ-014 The block SHALL have: global_int_en_o  output  1  equals mstatus[3] (MIE).

Function
REQ-015 Implemented CSRs SHALL be mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00; all 64 bits.
REQ-016 Writes SHALL take effect at the rising edge where the enable is high; value visible on outputs the following cycle.
REQ-017 When we_i and clint_we_i are both high, the ex write SHALL win for a shared address; writes to different addresses SHALL both complete in the same cycle.
REQ-018 Writes to mepc SHALL force bits [1:0] to 0; mtvec bits [1:0] SHALL be forced to 0 (direct mode only).
REQ-019 Writes to unimplemented addresses SHALL be ignored; reads of unimplemented addresses SHALL return 0.
REQ-020 rdata_o SHALL bypass: if we_i high and waddr_i[11:0] == raddr_i[11:0] (implemented address), rdata_o equals the masked wdata_i this cycle.
REQ-021 clint_data_o SHALL bypass identically against whichever write (per REQ-017 priority) targets clint_raddr_i this cycle.
REQ-022 mcycle SHALL increment by 1 every cycle when rst is high, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-023 A write to mcycle SHALL override that cycle's increment; next cycle mcycle equals written value, then resumes incrementing.
REQ-024 Reading mcycle SHALL return the current (pre-increment) registered value unless bypassed per REQ-020/021.
REQ-025 csr_mstatus/csr_mepc/csr_mtvec and global_int_en_o SHALL reflect registered values only (no bypass), so the CLINT mstatus read-modify-write sees the pre-write value.
REQ-026 Upper address bits [63:12] SHALL be ignored on all ports.

Reset
REQ-027 On rst low, all CSRs including mcycle SHALL clear to 0 asynchronously; global_int_en_o = 0, all outputs 0.
REQ-028 Reset asserted mid-write SHALL discard that write; first increment of mcycle SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-029 Reset release, idle 5 cycles -> mcycle reads 5 (±pipeline of sampling edge documented in bench), all other CSRs 0.
REQ-030 ex writes mstatus = 0x8 -> next cycle global_int_en_o = 1, csr_mstatus = 0x8; CLINT writes 0x80 -> global_int_en_o = 0.
REQ-031 Same cycle we_i mepc=0x1000, clint_we_i mepc=0x2000 -> csr_mepc = 0x1000; different addresses (mepc, mcause=11) -> both updated.
REQ-032 ex writes mtvec = 0x8000_0003 with raddr_i = 0x305 -> rdata_o = 0x8000_0000 same cycle; csr_mtvec = 0x8000_0000 next cycle.
REQ-033 Write mcycle = 0xFFFF_FFFF_FFFF_FFFE -> following cycles read ...FFFF then 0.
REQ-034 Write 0x1234 to 0x7C0, read 0x7C0 -> 0; no implemented CSR changes; rst pulsed low mid-sequence -> all outputs 0 without a clock edge.
